// File: rtl/photon_pkg.sv
// ---------------------------------------------------------------------------
// photon_pkg
// Shared definitions for the PHOTON-80/20/16 MixColumnsSerial stage.
//   - state geometry: 5x5 cells of 4 bits, 100-bit state, 20-bit columns
//   - GF(2^4) arithmetic with reduction polynomial x^4+x+1
//   - Serial(1,2,9,9,2) coefficient row
//   - FSM state encoding for the stepping controller
// ---------------------------------------------------------------------------
package photon_pkg;

    localparam int CELL_W  = 4;
    localparam int D       = 5;
    localparam int COL_W   = D * CELL_W;       // one column (or one row) in bits
    localparam int STATE_W = D * D * CELL_W;   // 100

    localparam logic [4:0] GF_POLY = 5'h13;    // x^4 + x + 1

    // Last row of the Serial companion matrix, applied to (v0..v4).
    localparam logic [CELL_W-1:0] SERIAL_COEF [D] = '{4'h1, 4'h2, 4'h9, 4'h9, 4'h2};

    localparam logic [2:0] CNT_LAST = 3'd4;    // step index that completes A^5

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mcs_state_e;

    // Multiply by x, reducing the carried-out x^4 term back into the low bits.
    function automatic logic [CELL_W-1:0] gf_mul2(input logic [CELL_W-1:0] a);
        return {a[CELL_W-2:0], 1'b0} ^ (a[CELL_W-1] ? GF_POLY[CELL_W-1:0] : '0);
    endfunction

    // 9 = x^3 + 1
    function automatic logic [CELL_W-1:0] gf_mul9(input logic [CELL_W-1:0] a);
        return gf_mul2(gf_mul2(gf_mul2(a))) ^ a;
    endfunction

    // Multiply by one of the constants that appear in SERIAL_COEF.
    function automatic logic [CELL_W-1:0] gf_mul_coef(input logic [CELL_W-1:0] coef,
                                                      input logic [CELL_W-1:0] a);
        case (coef)
            4'h1:    return a;
            4'h2:    return gf_mul2(a);
            4'h9:    return gf_mul9(a);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/photon_mcs_column.sv
// ---------------------------------------------------------------------------
// photon_mcs_column
// Combinational single Serial step on one 20-bit column.
// Row 0 sits in the top nibble: v_r = col_in[19-4r -: 4].
// The column shifts up by one cell and the new bottom cell is
//   f = 1*v0 ^ 2*v1 ^ 9*v2 ^ 9*v3 ^ 2*v4  over GF(2^4).
// Ports:
//   col_in   in  20  column before the step
//   col_out  out 20  column after the step (v1,v2,v3,v4,f)
// ---------------------------------------------------------------------------
module photon_mcs_column
    import photon_pkg::*;
(
    input  logic [COL_W-1:0] col_in,
    output logic [COL_W-1:0] col_out
);

    logic [CELL_W-1:0] v [D];
    logic [CELL_W-1:0] f;

    for (genvar r = 0; r < D; r++) begin : g_split
        assign v[r] = col_in[COL_W-1-CELL_W*r -: CELL_W];
    end

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch or loop,
        // so no path can leave it holding a previous value (an inferred latch).
        f = '0;
        for (int r = 0; r < D; r++) begin
            f = f ^ gf_mul_coef(SERIAL_COEF[r], v[r]);
        end
    end

    assign col_out = {v[1], v[2], v[3], v[4], f};

endmodule

// File: rtl/photon_mixcolserial.sv
// ---------------------------------------------------------------------------
// photon_mixcolserial
// MixColumnsSerial stage of the PHOTON-80/20/16 permutation. Accepts one
// 100-bit state, applies Serial(1,2,9,9,2) five times to all five columns in
// parallel, and presents the mixed state until the consumer takes it.
//
// Build option:
//   PHOTON_MCS_UNROLL_EN  when defined, all five Serial steps are chained
//                         combinationally and RUN lasts a single cycle.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    state_in holds a state to accept
//   in_ready   out  1    block can accept this cycle
//   state_in   in   100  input state, cell (r,c) = state_in[99-20r-4c -: 4]
//   out_valid  out  1    state_out holds the result
//   out_ready  in   1    consumer takes the result this cycle
//   state_out  out  100  mixed state, same layout as state_in
//   busy       out  1    high while stepping (RUN)
// ---------------------------------------------------------------------------
module photon_mixcolserial
    import photon_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic               busy
);

    mcs_state_e         state_q, state_d;
    logic [STATE_W-1:0] st;
    logic [STATE_W-1:0] mix_next;
    logic               load;
    logic               last_step;

    logic [COL_W-1:0] col_cur [D];
    logic [COL_W-1:0] col_nxt [D];

    // Columns are not contiguous in the row-major state: gather each column's
    // cells on the way in and scatter them back on the way out.
    for (genvar c = 0; c < D; c++) begin : g_col
        for (genvar r = 0; r < D; r++) begin : g_row
            assign col_cur[c][COL_W-1-CELL_W*r -: CELL_W] =
                st[STATE_W-1-COL_W*r-CELL_W*c -: CELL_W];
            assign mix_next[STATE_W-1-COL_W*r-CELL_W*c -: CELL_W] =
                col_nxt[c][COL_W-1-CELL_W*r -: CELL_W];
        end

`ifdef PHOTON_MCS_UNROLL_EN
        logic [COL_W-1:0] chain [D+1];
        assign chain[0] = col_cur[c];
        for (genvar k = 0; k < D; k++) begin : g_step
            photon_mcs_column u_step (
                .col_in  (chain[k]),
                .col_out (chain[k+1])
            );
        end
        assign col_nxt[c] = chain[D];
`else
        photon_mcs_column u_step (
            .col_in  (col_cur[c]),
            .col_out (col_nxt[c])
        );
`endif
    end

`ifdef PHOTON_MCS_UNROLL_EN
    // The whole A^5 is applied in one RUN cycle.
    assign last_step = 1'b1;
`else
    logic [2:0] cnt;
    assign last_step = (cnt == CNT_LAST);
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block evaluation order.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                // Result leaves and a new state may enter on the same edge.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load    = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the working register is reset even though it is a datapath
            // register, because state_out must read zero straight out of reset.
            st <= '0;
`ifndef PHOTON_MCS_UNROLL_EN
            cnt <= '0;
`endif
        end else if (load) begin
            st <= state_in;
`ifndef PHOTON_MCS_UNROLL_EN
            cnt <= '0;
`endif
        end else if (busy) begin
            st <= mix_next;
`ifndef PHOTON_MCS_UNROLL_EN
            cnt <= cnt + 3'd1;
`endif
        end
    end

    assign state_out = st;

endmodule

// File: tb/tb_photon_mixcolserial.sv
// ---------------------------------------------------------------------------
// tb_photon_mixcolserial
// Self-checking bench: a cell-array reference of Serial(1,2,9,9,2)^5 feeds an
// expected-result queue; one compare process checks state_out every cycle
// out_valid is high. Directed sequences cover reset, latency, backpressure,
// back-to-back accept and reset in the middle of RUN.
// ---------------------------------------------------------------------------
module tb_photon_mixcolserial;

`ifdef PHOTON_MCS_UNROLL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 5;
`endif

    localparam logic [99:0] SINGLE     = 100'h10000_00000_00000_00000_00000;
    localparam logic [99:0] SINGLE_EXP = 100'h10000_20000_D0000_10000_E0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [99:0] state_in;
    logic        out_valid;
    logic        out_ready;
    logic [99:0] state_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [99:0] exp_q [$];

    photon_mixcolserial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [99:0] act, input logic [99:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Generic shift-and-add multiply in GF(2^4) mod x^4+x+1.
    function automatic int gmul(input int a, input int b);
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            if ((b & 1) != 0) r = r ^ a;
            b = b >> 1;
            a = a << 1;
            if ((a & 16) != 0) a = a ^ 19;
        end
        return r;
    endfunction

    // Reference: five Serial steps on a 5x5 cell array.
    function automatic logic [99:0] ref_mix(input logic [99:0] s);
        int m [5][5];
        int coef [5] = '{1, 2, 9, 9, 2};
        logic [99:0] o;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                m[r][c] = int'(s[99-20*r-4*c -: 4]);
        for (int step = 0; step < 5; step++) begin
            for (int c = 0; c < 5; c++) begin
                int f = 0;
                for (int r = 0; r < 5; r++) f = f ^ gmul(coef[r], m[r][c]);
                for (int r = 0; r < 4; r++) m[r][c] = m[r+1][c];
                m[4][c] = f;
            end
        end
        o = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                o[99-20*r-4*c -: 4] = 4'(m[r][c]);
        return o;
    endfunction

    // Scoreboard bookkeeping: a result leaves before a new one enters.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) exp_q.push_back(ref_mix(state_in));
        end
    end

    // Compare process: every cycle a result is presented.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() > 0) check("state_out", state_out, exp_q[0]);
            else                  check("unexpected_out_valid", 100'(out_valid), 100'(0));
        end
    end

    task automatic accept(input logic [99:0] s);
        int k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", 100'(in_ready), 100'(1));
        in_valid = 1'b1;
        state_in = s;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts negedges after the accepting edge until out_valid is seen.
    task automatic wait_out(output int n, output int b);
        n = 0;
        b = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) b++;
        end while (!out_valid && n < 50);
    endtask

    // Called at a negedge with out_valid high; hands the result over.
    task automatic drain(input bit rnd);
        int k = 0;
        bit taken = 1'b0;
        while (!taken && k < 100) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            taken = out_ready;
            #1 out_ready = 1'b0;
            k++;
            if (!taken) @(negedge clk);
        end
        check("drain_taken", 100'(taken), 100'(1));
    endtask

    initial begin
        int n, b;
        logic [127:0] rnd;
        logic [99:0] held;

        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, b;
        logic [127:0] rnd;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;

        // Pin the reference model with hand-derived values.
        check("model_zero", ref_mix('0), '0);
        check("model_single", ref_mix(SINGLE), SINGLE_EXP);

        repeat (3) @(posedge clk);
        #1;
        check("rst_state_out", state_out, '0);
        check("rst_in_ready", 100'(in_ready), 100'(1));
        check("rst_out_valid", 100'(out_valid), 100'(0));
        check("rst_busy", 100'(busy), 100'(0));
        rst = 1'b0;

        // Zero state.
        accept('0);
        wait_out(n, b);
        check("zero_latency", 100'(n), 100'(LAT + 1));
        check("zero_busy_cycles", 100'(b), 100'(LAT));
        check("zero_result", state_out, '0);
        drain(1'b0);

        // Single cell, then 10 cycles of backpressure.
        accept(SINGLE);
        wait_out(n, b);
        check("single_latency", 100'(n), 100'(LAT + 1));
        check("single_result", state_out, SINGLE_EXP);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 100'(out_valid), 100'(1));
            check("bp_state_out", state_out, SINGLE_EXP);
            check("bp_in_ready", 100'(in_ready), 100'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp_idle_out_valid", 100'(out_valid), 100'(0));
        check("bp_idle_in_ready", 100'(in_ready), 100'(1));
        check("bp_idle_busy", 100'(busy), 100'(0));

        // Back-to-back accept in DONE.
        accept(SINGLE);
        wait_out(n, b);
        check("b2b_first_latency", 100'(n), 100'(LAT + 1));
        check("b2b_in_ready_done", 100'(in_ready), 100'(0));
        in_valid  = 1'b1;
        state_in  = SINGLE;
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready_follows", 100'(in_ready), 100'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(n, b);
        check("b2b_second_latency", 100'(n), 100'(LAT + 1));
        check("b2b_second_result", state_out, SINGLE_EXP);
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("b2b_idle_out_valid", 100'(out_valid), 100'(0));

        // Reset during the third serial step (or right after the accept when
        // all steps happen at once).
        rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
        accept(rnd[99:0]);
        if (LAT > 1) begin
            repeat (2) @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_in_ready", 100'(in_ready), 100'(1));
        check("midrst_out_valid", 100'(out_valid), 100'(0));
        check("midrst_busy", 100'(busy), 100'(0));
        rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
        accept(rnd[99:0]);
        wait_out(n, b);
        check("midrst_fresh_latency", 100'(n), 100'(LAT + 1));
        check("midrst_fresh_result", state_out, ref_mix(rnd[99:0]));
        drain(1'b0);

        // Random states with random consumer backpressure.
        for (int t = 0; t < 20; t++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            accept(rnd[99:0]);
            wait_out(n, b);
            check("rand_latency", 100'(n), 100'(LAT + 1));
            drain(1'b1);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 100'(exp_q.size()), 100'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
